id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/hazard_detect.sv | 20 ++
 rtl/id_ex_stage.sv | 107 ++++++++++
 tb/tb_id_ex_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, ALU op classes and the
// bubble counter width used by the ID/EX pipeline stage.
package cpu_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned ADDR_W_DEF   = 5;
    localparam int unsigned BUBBLE_CNT_W = 16;

    localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_CNT_MAX = '1;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_LOGIC = 2'b11
    } alu_op_e;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] cnt);
        return (cnt == BUBBLE_CNT_MAX) ? cnt : cnt + BUBBLE_CNT_W'(1);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: the instruction in EX is a load whose destination
// is a source of the instruction in ID. Register 0 never creates a hazard.
module hazard_detect
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] RSaddr_i,
    input  logic [ADDR_W-1:0] RTaddr_i,
    input  logic              valid_o,
    input  logic              MemRead_o,
    input  logic [ADDR_W-1:0] RDaddr_o,
    output logic              hazard
);

    assign hazard = valid_i & valid_o & MemRead_o & (RDaddr_o != '0)
                  & ((RDaddr_o == RSaddr_i) | (RDaddr_o == RTaddr_i));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, hold and load-use bubble insertion,
// plus a saturating count of inserted bubbles.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    input  logic [ADDR_W-1:0]       RSaddr_i,
    input  logic [ADDR_W-1:0]       RTaddr_i,
    input  logic [ADDR_W-1:0]       RDaddr_i,
    input  logic [DATA_W-1:0]       RSdata_i,
    input  logic [DATA_W-1:0]       RTdata_i,
    input  logic [DATA_W-1:0]       imm_i,
    input  logic                    RegWrite_i,
    input  logic                    MemRead_i,
    input  logic                    MemWrite_i,
    input  logic                    MemtoReg_i,
    input  logic                    ALUSrc_i,
    input  logic [1:0]              ALUOp_i,
    input  logic                    flush_i,
    input  logic                    hold_i,
    output logic                    valid_o,
    output logic [ADDR_W-1:0]       RSaddr_o,
    output logic [ADDR_W-1:0]       RTaddr_o,
    output logic [ADDR_W-1:0]       RDaddr_o,
    output logic [DATA_W-1:0]       RSdata_o,
    output logic [DATA_W-1:0]       RTdata_o,
    output logic [DATA_W-1:0]       imm_o,
    output logic                    RegWrite_o,
    output logic                    MemRead_o,
    output logic                    MemWrite_o,
    output logic                    MemtoReg_o,
    output logic                    ALUSrc_o,
    output logic [1:0]              ALUOp_o,
    output logic                    stall_o,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt_o
);

    logic                    hazard;
    logic                    bubble;
    logic                    clear;
    logic [BUBBLE_CNT_W-1:0] bubble_cnt_q;

    hazard_detect #(.ADDR_W(ADDR_W)) u_hazard_detect (
        .valid_i   (valid_i),
        .RSaddr_i  (RSaddr_i),
        .RTaddr_i  (RTaddr_i),
        .valid_o   (valid_o),
        .MemRead_o (MemRead_o),
        .RDaddr_o  (RDaddr_o),
        .hazard    (hazard)
    );

    // Flush kills the incoming instruction, so it also cancels the stall.
    assign stall_o = (hazard & ~flush_i) | hold_i;
    assign bubble  = hazard & ~flush_i & ~hold_i;
    assign clear   = flush_i | bubble;

    // Pipeline register: flush > hold > bubble > load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || clear) begin
            valid_o    <= 1'b0;
            RSaddr_o   <= '0;
            RTaddr_o   <= '0;
            RDaddr_o   <= '0;
            RSdata_o   <= '0;
            RTdata_o   <= '0;
            imm_o      <= '0;
            RegWrite_o <= 1'b0;
            MemRead_o  <= 1'b0;
            MemWrite_o <= 1'b0;
            MemtoReg_o <= 1'b0;
            ALUSrc_o   <= 1'b0;
            ALUOp_o    <= 2'b00;
        end else if (!hold_i) begin
            valid_o    <= valid_i;
            RSaddr_o   <= RSaddr_i;
            RTaddr_o   <= RTaddr_i;
            RDaddr_o   <= RDaddr_i;
            RSdata_o   <= RSdata_i;
            RTdata_o   <= RTdata_i;
            imm_o      <= imm_i;
            RegWrite_o <= valid_i & RegWrite_i;
            MemRead_o  <= valid_i & MemRead_i;
            MemWrite_o <= valid_i & MemWrite_i;
            MemtoReg_o <= valid_i & MemtoReg_i;
            ALUSrc_o   <= valid_i & ALUSrc_i;
            ALUOp_o    <= valid_i ? ALUOp_i : 2'b00;
        end
    end

    // Bubble counter only written on a bubble so its value is otherwise untouched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_cnt_q <= '0;
        end else if (bubble) begin
            bubble_cnt_q <= sat_inc(bubble_cnt_q);
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written
// hold/reset/saturation sequences and random traffic against a reference model.
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i;
    logic [31:0] RSdata_i, RTdata_i, imm_i;
    logic        RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, ALUSrc_i;
    logic [1:0]  ALUOp_i;
    logic        flush_i, hold_i;
    logic        valid_o;
    logic [4:0]  RSaddr_o, RTaddr_o, RDaddr_o;
    logic [31:0] RSdata_o, RTdata_o, imm_o;
    logic        RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, ALUSrc_o;
    logic [1:0]  ALUOp_o;
    logic        stall_o;
    logic [15:0] bubble_cnt_o;

    id_ex_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
        .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .imm_i(imm_i),
        .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .MemtoReg_i(MemtoReg_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
        .flush_i(flush_i), .hold_i(hold_i), .valid_o(valid_o),
        .RSaddr_o(RSaddr_o), .RTaddr_o(RTaddr_o), .RDaddr_o(RDaddr_o),
        .RSdata_o(RSdata_o), .RTdata_o(RTdata_o), .imm_o(imm_o),
        .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .MemtoReg_o(MemtoReg_o), .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o),
        .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit        v;
        bit [4:0]  rs, rt, rd;
        bit [31:0] rsd, rtd, imm;
        bit        rw, mr, mw, m2r, als;
        bit [1:0]  aop;
        bit        flush, hold;
    } in_t;

    // Model state: what the stage should present, plus whether data fields are defined.
    typedef struct {
        bit        v;
        bit [4:0]  rs, rt, rd;
        bit [31:0] rsd, rtd, imm;
        bit        rw, mr, mw, m2r, als;
        bit [1:0]  aop;
        bit [15:0] cnt;
        bit        dk;
    } st_t;

    typedef struct {
        in_t       in;
        bit        e_stall, e_v, e_rw, e_mr, e_mw;
        bit [4:0]  e_rd;
        bit [31:0] e_rsd;
        bit [15:0] e_cnt;
        bit        cd;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    st_t  m;
    bit   samp_stall, exp_stall;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic in_t mk(bit v, int rs, int rt, int rd, int rsd, bit rw, bit mr, bit fl, bit hd);
        in_t i;
        i.v = v; i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
        i.rsd = 32'(rsd); i.rtd = 32'(rsd) ^ 32'hFFFF_0000; i.imm = 32'(rsd) + 32'd4;
        i.rw = rw; i.mr = mr; i.mw = 1'b0; i.m2r = mr; i.als = mr;
        i.aop = mr ? 2'(ALU_ADD) : 2'(ALU_FUNCT);
        i.flush = fl; i.hold = hd;
        return i;
    endfunction

    function automatic in_t rnd_in();
        in_t i;
        i.v = ($urandom_range(0, 9) < 8);
        i.rs = 5'($urandom_range(0, 3)); i.rt = 5'($urandom_range(0, 3));
        i.rd = 5'($urandom_range(0, 3));
        i.rsd = $urandom; i.rtd = $urandom; i.imm = $urandom;
        i.rw = 1'($urandom); i.mr = ($urandom_range(0, 9) < 4); i.mw = 1'($urandom);
        i.m2r = 1'($urandom); i.als = 1'($urandom); i.aop = 2'($urandom_range(0, 3));
        i.flush = ($urandom_range(0, 99) < 8); i.hold = ($urandom_range(0, 99) < 12);
        return i;
    endfunction

    function automatic st_t model_reset();
        st_t s;
        s = '{default: '0};
        s.dk = 1'b1;
        return s;
    endfunction

    function automatic bit load_use(st_t s, in_t i);
        return i.v && s.v && s.mr && s.rd != 5'd0 && (s.rd == i.rs || s.rd == i.rt);
    endfunction

    function automatic st_t model_step(st_t s, in_t i);
        st_t n;
        n = s;
        if (i.flush) begin
            n = model_reset();
            n.cnt = s.cnt;
        end else if (i.hold) begin
            n = s;
        end else if (load_use(s, i)) begin
            n = model_reset();
            n.cnt = (s.cnt == 16'hFFFF) ? s.cnt : s.cnt + 16'd1;
            n.dk = 1'b0;
        end else begin
            n.v = i.v; n.rs = i.rs; n.rt = i.rt; n.rd = i.rd;
            n.rsd = i.rsd; n.rtd = i.rtd; n.imm = i.imm;
            n.rw = i.v & i.rw; n.mr = i.v & i.mr; n.mw = i.v & i.mw;
            n.m2r = i.v & i.m2r; n.als = i.v & i.als; n.aop = i.v ? i.aop : 2'd0;
            n.dk = 1'b1;
        end
        return n;
    endfunction

    task automatic drive(input in_t i);
        valid_i = i.v; RSaddr_i = i.rs; RTaddr_i = i.rt; RDaddr_i = i.rd;
        RSdata_i = i.rsd; RTdata_i = i.rtd; imm_i = i.imm;
        RegWrite_i = i.rw; MemRead_i = i.mr; MemWrite_i = i.mw;
        MemtoReg_i = i.m2r; ALUSrc_i = i.als; ALUOp_i = i.aop;
        flush_i = i.flush; hold_i = i.hold;
    endtask

    // One cycle: drive at negedge, sample stall mid-cycle, advance model, settle after posedge.
    task automatic apply(input in_t i);
        @(negedge clk_i);
        drive(i);
        #1;
        samp_stall = stall_o;
        exp_stall = (load_use(m, i) && !i.flush) || i.hold;
        m = model_step(m, i);
        @(posedge clk_i);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, " valid_o"}, 32'(valid_o), 32'(m.v));
        chk({tag, " RegWrite_o"}, 32'(RegWrite_o), 32'(m.rw));
        chk({tag, " MemRead_o"}, 32'(MemRead_o), 32'(m.mr));
        chk({tag, " MemWrite_o"}, 32'(MemWrite_o), 32'(m.mw));
        chk({tag, " MemtoReg_o"}, 32'(MemtoReg_o), 32'(m.m2r));
        chk({tag, " ALUSrc_o"}, 32'(ALUSrc_o), 32'(m.als));
        chk({tag, " ALUOp_o"}, 32'(ALUOp_o), 32'(m.aop));
        chk({tag, " bubble_cnt_o"}, 32'(bubble_cnt_o), 32'(m.cnt));
        if (m.dk) begin
            chk({tag, " RSaddr_o"}, 32'(RSaddr_o), 32'(m.rs));
            chk({tag, " RTaddr_o"}, 32'(RTaddr_o), 32'(m.rt));
            chk({tag, " RDaddr_o"}, 32'(RDaddr_o), 32'(m.rd));
            chk({tag, " RSdata_o"}, RSdata_o, m.rsd);
            chk({tag, " RTdata_o"}, RTdata_o, m.rtd);
            chk({tag, " imm_o"}, imm_o, m.imm);
        end
    endtask

    vec_t tbl[9];
    in_t  vi;
    bit [15:0] cnt_snap;

    initial begin
        rst_i = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        m = model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset valid_o", 32'(valid_o), 32'd0);
        chk("reset RDaddr_o", 32'(RDaddr_o), 32'd0);
        chk("reset RSdata_o", RSdata_o, 32'd0);
        chk("reset bubble_cnt_o", 32'(bubble_cnt_o), 32'd0);
        chk("reset stall_o", 32'(stall_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // in, stall, valid, rw, mr, mw, rd, rsd, cnt, data-checked
        tbl[0] = '{mk(1, 1, 2, 5, 32'h1234, 1, 0, 0, 0), 0, 1, 1, 0, 0, 5, 32'h1234, 0, 1};
        tbl[1] = '{mk(1, 5, 0, 8, 32'hAAAA, 1, 1, 0, 0), 0, 1, 1, 1, 0, 8, 32'hAAAA, 0, 1};
        tbl[2] = '{mk(1, 8, 2, 9, 32'h0055, 1, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[3] = '{mk(1, 8, 2, 9, 32'h0055, 1, 0, 0, 0), 0, 1, 1, 0, 0, 9, 32'h0055, 1, 1};
        tbl[4] = '{mk(1, 9, 1, 0, 32'h0011, 1, 1, 0, 0), 0, 1, 1, 1, 0, 0, 32'h0011, 1, 1};
        tbl[5] = '{mk(1, 3, 0, 4, 32'h0077, 1, 0, 0, 0), 0, 1, 1, 0, 0, 4, 32'h0077, 1, 1};
        tbl[6] = '{mk(1, 1, 1, 8, 32'h0066, 1, 1, 0, 0), 0, 1, 1, 1, 0, 8, 32'h0066, 1, 1};
        tbl[7] = '{mk(1, 8, 1, 2, 32'h0088, 1, 0, 1, 0), 0, 0, 0, 0, 0, 0, 32'h0000, 1, 1};
        tbl[8] = '{mk(0, 2, 3, 8, 32'h0099, 1, 1, 0, 0), 0, 0, 0, 0, 0, 8, 32'h0099, 1, 1};
        tbl[8].in.mw = 1'b1;

        for (int k = 0; k < 9; k++) begin
            apply(tbl[k].in);
            chk($sformatf("vec%0d stall_o", k), 32'(samp_stall), 32'(tbl[k].e_stall));
            chk($sformatf("vec%0d valid_o", k), 32'(valid_o), 32'(tbl[k].e_v));
            chk($sformatf("vec%0d RegWrite_o", k), 32'(RegWrite_o), 32'(tbl[k].e_rw));
            chk($sformatf("vec%0d MemRead_o", k), 32'(MemRead_o), 32'(tbl[k].e_mr));
            chk($sformatf("vec%0d MemWrite_o", k), 32'(MemWrite_o), 32'(tbl[k].e_mw));
            chk($sformatf("vec%0d bubble_cnt_o", k), 32'(bubble_cnt_o), 32'(tbl[k].e_cnt));
            if (tbl[k].cd) begin
                chk($sformatf("vec%0d RDaddr_o", k), 32'(RDaddr_o), 32'(tbl[k].e_rd));
                chk($sformatf("vec%0d RSdata_o", k), RSdata_o, tbl[k].e_rsd);
            end
        end

        // Hold for three cycles over a pending load-use: nothing moves, no bubble counted.
        apply(mk(1, 1, 2, 7, 32'h4242, 1, 1, 0, 0));
        cnt_snap = m.cnt;
        for (int k = 0; k < 3; k++) begin
            vi = rnd_in();
            vi.v = 1'b1; vi.rs = 5'd7; vi.flush = 1'b0; vi.hold = 1'b1;
            apply(vi);
            chk("hold stall_o", 32'(samp_stall), 32'd1);
            chk("hold valid_o", 32'(valid_o), 32'd1);
            chk("hold RDaddr_o", 32'(RDaddr_o), 32'd7);
            chk("hold RSdata_o", RSdata_o, 32'h4242);
            chk("hold MemRead_o", 32'(MemRead_o), 32'd1);
            chk("hold bubble_cnt_o", 32'(bubble_cnt_o), 32'(cnt_snap));
        end
        vi.hold = 1'b0;
        apply(vi);
        chk("post-hold stall_o", 32'(samp_stall), 32'd1);
        chk("post-hold valid_o", 32'(valid_o), 32'd0);
        chk("post-hold bubble_cnt_o", 32'(bubble_cnt_o), 32'(cnt_snap + 16'd1));

        // Asynchronous reset in the middle of a load-use stall.
        apply(mk(1, 1, 2, 8, 32'h0031, 1, 1, 0, 0));
        @(negedge clk_i);
        vi = mk(1, 8, 0, 3, 32'h0abc, 1, 0, 0, 0);
        drive(vi);
        #1;
        chk("pre-reset stall_o", 32'(stall_o), 32'd1);
        #1 rst_i = 1'b1;
        #1;
        chk("async valid_o", 32'(valid_o), 32'd0);
        chk("async RDaddr_o", 32'(RDaddr_o), 32'd0);
        chk("async RSdata_o", RSdata_o, 32'd0);
        chk("async RegWrite_o", 32'(RegWrite_o), 32'd0);
        chk("async MemRead_o", 32'(MemRead_o), 32'd0);
        chk("async bubble_cnt_o", 32'(bubble_cnt_o), 32'd0);
        chk("async stall_o", 32'(stall_o), 32'd0);
        #1 rst_i = 1'b0;
        m = model_step(model_reset(), vi);
        @(posedge clk_i);
        #1;
        chk("after-reset valid_o", 32'(valid_o), 32'd1);
        chk("after-reset RDaddr_o", 32'(RDaddr_o), 32'd3);
        chk("after-reset RSdata_o", RSdata_o, 32'h0abc);
        cmp_model("after-reset");

        // Counter saturation from just below the top.
        force dut.bubble_cnt_q = 16'hFFFE;
        #1 release dut.bubble_cnt_q;
        m.cnt = 16'hFFFE;
        chk("preset bubble_cnt_o", 32'(bubble_cnt_o), 32'h0000_FFFE);
        for (int k = 0; k < 3; k++) begin
            apply(mk(1, 0, 0, 6, k, 1, 1, 0, 0));
            apply(mk(1, 6, 1, 2, k, 1, 0, 0, 0));
            chk("sat stall_o", 32'(samp_stall), 32'd1);
            chk("sat bubble_cnt_o", 32'(bubble_cnt_o), 32'h0000_FFFF);
            apply(mk(1, 6, 1, 2, k, 1, 0, 0, 0));
        end

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            apply(rnd_in());
            chk("rand stall_o", 32'(samp_stall), 32'(exp_stall));
            cmp_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
